// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared state and mode encodings for the TDM mux scanner
package mux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_sel_n.sv
// rtl/mux_sel_n.sv - combinational N_CH:1 W-bit slice selector with out-of-range flag
module mux_sel_n #(
    parameter int N_CH  = 8,
    parameter int W     = 1,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH*W-1:0] i_data,
    input  logic [SEL_W-1:0]  i_idx,
    output logic [W-1:0]      o_data,
    output logic              o_oob
);

    // Compare against each legal index so no slice ever goes past the packed vector.
    always_comb begin
        o_data = '0;
        o_oob  = 1'b1;
        for (int k = 0; k < N_CH; k++) begin
            if (i_idx == SEL_W'(k)) begin
                o_data = i_data[k*W +: W];
                o_oob  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/tdm_mux_scanner.sv
// rtl/tdm_mux_scanner.sv - N-channel registered mux with manual select and dwell-timed scan
module tdm_mux_scanner
    import mux_pkg::*;
#(
    parameter int N_CH  = 8,
    parameter int W     = 1,
    parameter int SEL_W = $clog2(N_CH),
    parameter int DWELL = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N_CH*W-1:0] i_in_data,
    input  logic              i_en,
    input  logic              i_mode,
    input  logic [SEL_W-1:0]  i_sel_in,
    output logic [W-1:0]      o_out_data,
    output logic [SEL_W-1:0]  o_out_ch,
    output logic              o_out_valid,
    output logic              o_frame_done
);

    localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    state_t           r_state;
    logic [SEL_W-1:0] r_ptr;
    logic [DW_W-1:0]  r_dwell;

    logic             w_scan;
    logic [SEL_W-1:0] w_ptr_eff;
    logic [DW_W-1:0]  w_dwell_eff;
    logic [SEL_W-1:0] w_idx;
    logic [W-1:0]     w_sel_data;
    logic             w_oob;
    logic             w_last_ch;

    // Entering scan from another state always begins a fresh frame at channel 0.
    assign w_scan      = i_en && (i_mode == MODE_SCAN);
    assign w_ptr_eff   = (r_state == SCAN) ? r_ptr   : '0;
    assign w_dwell_eff = (r_state == SCAN) ? r_dwell : '0;
    assign w_idx       = w_scan ? w_ptr_eff : i_sel_in;
    assign w_last_ch   = (w_ptr_eff == SEL_W'(N_CH - 1));

    mux_sel_n #(
        .N_CH  (N_CH),
        .W     (W),
        .SEL_W (SEL_W)
    ) u_sel (
        .i_data (i_in_data),
        .i_idx  (w_idx),
        .o_data (w_sel_data),
        .o_oob  (w_oob)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_dwell      <= '0;
            o_out_data   <= '0;
            o_out_ch     <= '0;
            o_out_valid  <= 1'b0;
            o_frame_done <= 1'b0;
        end else if (!i_en) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_dwell      <= '0;
            o_out_valid  <= 1'b0;
            o_frame_done <= 1'b0;
        end else if (i_mode == MODE_MANUAL) begin
            r_state      <= MANUAL;
            r_ptr        <= '0;
            r_dwell      <= '0;
            o_out_data   <= w_sel_data;
            o_out_ch     <= i_sel_in;
            o_out_valid  <= !w_oob;
            o_frame_done <= 1'b0;
        end else begin
            r_state     <= SCAN;
            o_out_data  <= w_sel_data;
            o_out_ch    <= w_ptr_eff;
            o_out_valid <= 1'b1;
            if (w_dwell_eff == DW_W'(DWELL - 1)) begin
                r_dwell      <= '0;
                r_ptr        <= w_last_ch ? '0 : w_ptr_eff + SEL_W'(1);
                o_frame_done <= w_last_ch;
            end else begin
                r_dwell      <= w_dwell_eff + DW_W'(1);
                r_ptr        <= w_ptr_eff;
                o_frame_done <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tdm_mux_scanner.sv
// tb/tb_tdm_mux_scanner.sv - scoreboard bench for three tdm_mux_scanner configurations
module tb_tdm_mux_scanner;

    typedef struct {
        logic [3:0] d;
        logic [2:0] ch;
        logic       v;
        logic       fd;
        string      tag;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int n_cmp = 0;
    int n_bad = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst  [3];
    logic        en   [3];
    logic        mode [3];
    logic [2:0]  sel  [3];
    logic [23:0] din  [3];

    logic [0:0] a_d;
    logic [2:0] a_ch;
    logic       a_v, a_fd;
    logic [0:0] b_d;
    logic [2:0] b_ch;
    logic       b_v, b_fd;
    logic [3:0] c_d;
    logic [2:0] c_ch;
    logic       c_v, c_fd;

    tdm_mux_scanner #(.N_CH(8), .W(1), .DWELL(1)) u_a (
        .i_clk(clk), .i_rst(rst[0]), .i_in_data(din[0][7:0]), .i_en(en[0]),
        .i_mode(mode[0]), .i_sel_in(sel[0]), .o_out_data(a_d), .o_out_ch(a_ch),
        .o_out_valid(a_v), .o_frame_done(a_fd)
    );

    tdm_mux_scanner #(.N_CH(8), .W(1), .DWELL(3)) u_b (
        .i_clk(clk), .i_rst(rst[1]), .i_in_data(din[1][7:0]), .i_en(en[1]),
        .i_mode(mode[1]), .i_sel_in(sel[1]), .o_out_data(b_d), .o_out_ch(b_ch),
        .o_out_valid(b_v), .o_frame_done(b_fd)
    );

    tdm_mux_scanner #(.N_CH(6), .W(4), .DWELL(1)) u_c (
        .i_clk(clk), .i_rst(rst[2]), .i_in_data(din[2]), .i_en(en[2]),
        .i_mode(mode[2]), .i_sel_in(sel[2]), .o_out_data(c_d), .o_out_ch(c_ch),
        .o_out_valid(c_v), .o_frame_done(c_fd)
    );

    task automatic push(input int id, input exp_t x);
        if (id == 0) q0.push_back(x);
        else if (id == 1) q1.push_back(x);
        else q2.push_back(x);
    endtask

    task automatic cyc(input int id, input logic r, input logic e, input logic m,
                       input logic [2:0] s, input logic [23:0] d,
                       input logic [3:0] xd, input logic [2:0] xc,
                       input logic xv, input logic xf, input string tag);
        exp_t x;
        @(negedge clk);
        rst[id]  = r;
        en[id]   = e;
        mode[id] = m;
        sel[id]  = s;
        din[id]  = d;
        x.d = xd; x.ch = xc; x.v = xv; x.fd = xf; x.tag = tag;
        push(id, x);
    endtask

    task automatic reset_all(input logic r, input string tag);
        exp_t x;
        @(negedge clk);
        x.d = '0; x.ch = '0; x.v = 1'b0; x.fd = 1'b0; x.tag = tag;
        for (int i = 0; i < 3; i++) begin
            rst[i] = r; en[i] = 1'b0; mode[i] = 1'b0; sel[i] = '0; din[i] = '0;
            push(i, x);
        end
    endtask

    task automatic chk(input int id, input logic [3:0] d, input logic [2:0] ch,
                       input logic v, input logic fd);
        exp_t x;
        bit   have;
        have = 1'b0;
        if (id == 0 && q0.size() > 0) begin x = q0.pop_front(); have = 1'b1; end
        if (id == 1 && q1.size() > 0) begin x = q1.pop_front(); have = 1'b1; end
        if (id == 2 && q2.size() > 0) begin x = q2.pop_front(); have = 1'b1; end
        if (have) begin
            n_cmp++;
            if (d !== x.d || ch !== x.ch || v !== x.v || fd !== x.fd) begin
                n_bad++;
                $display("FAIL dut%0d %s: got d=%h ch=%0d v=%b fd=%b, want d=%h ch=%0d v=%b fd=%b",
                         id, x.tag, d, ch, v, fd, x.d, x.ch, x.v, x.fd);
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        chk(0, {3'b000, a_d}, a_ch, a_v, a_fd);
        chk(1, {3'b000, b_d}, b_ch, b_v, b_fd);
        chk(2, c_d, c_ch, c_v, c_fd);
    end

    logic [7:0]  ab = 8'b11001101;
    logic [7:0]  bb = 8'b01101001;
    logic [3:0]  cval [6] = '{4'h1, 4'hA, 4'h5, 4'hF, 4'h3, 4'hC};
    logic [23:0] da, db, dc;

    initial begin
        da = {16'h0, ab};
        db = {16'h0, bb};
        dc = 24'hC3F5A1;
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; en[i] = 1'b0; mode[i] = 1'b0; sel[i] = '0; din[i] = '0;
        end

        reset_all(1'b1, "reset");
        reset_all(1'b0, "idle_after_reset");

        // manual select walks all eight channels
        for (int k = 0; k < 8; k++)
            cyc(0, 0, 1, 0, 3'(k), da, {3'b0, ab[k]}, 3'(k), 1, 0, "manual");
        cyc(0, 0, 0, 0, 0, da, {3'b0, ab[7]}, 3'd7, 0, 0, "idle_hold");

        // two full frames, DWELL=1
        for (int k = 0; k < 16; k++)
            cyc(0, 0, 1, 1, 0, da, {3'b0, ab[k%8]}, 3'(k%8), 1, (k%8 == 7), "scan_d1");
        cyc(0, 0, 0, 0, 0, da, {3'b0, ab[7]}, 3'd7, 0, 0, "idle_after_scan");

        // scan -> manual mid-frame -> scan restarts at channel 0
        for (int k = 0; k < 4; k++)
            cyc(0, 0, 1, 1, 0, da, {3'b0, ab[k]}, 3'(k), 1, 0, "scan_partial");
        cyc(0, 0, 1, 0, 6, da, {3'b0, ab[6]}, 3'd6, 1, 0, "switch_manual");
        for (int k = 0; k < 9; k++)
            cyc(0, 0, 1, 1, 0, da, {3'b0, ab[k%8]}, 3'(k%8), 1, (k == 7), "scan_restart");
        cyc(0, 0, 0, 0, 0, da, {3'b0, ab[0]}, 3'd0, 0, 0, "idle2");

        // reset mid-scan
        for (int k = 0; k < 5; k++)
            cyc(0, 0, 1, 1, 0, da, {3'b0, ab[k]}, 3'(k), 1, 0, "scan_pre_rst");
        cyc(0, 1, 1, 1, 0, da, 4'h0, 3'd0, 0, 0, "rst_mid_scan");
        for (int k = 0; k < 3; k++)
            cyc(0, 0, 1, 1, 0, da, {3'b0, ab[k]}, 3'(k), 1, 0, "scan_post_rst");
        cyc(0, 0, 0, 0, 0, da, {3'b0, ab[2]}, 3'd2, 0, 0, "idle3");

        // DWELL=3: two frames of 24 cycles
        for (int k = 0; k < 48; k++)
            cyc(1, 0, 1, 1, 0, db, {3'b0, bb[(k/3)%8]}, 3'((k/3)%8), 1, (k%24 == 23), "scan_d3");
        cyc(1, 0, 0, 0, 0, db, {3'b0, bb[7]}, 3'd7, 0, 0, "idle_d3");

        // in_data changes inside a dwell appear on the next edge
        cyc(1, 0, 1, 1, 0, 24'h000001, 4'h1, 3'd0, 1, 0, "dwell_live0");
        cyc(1, 0, 1, 1, 0, 24'h000000, 4'h0, 3'd0, 1, 0, "dwell_live1");
        cyc(1, 0, 1, 1, 0, 24'h000001, 4'h1, 3'd0, 1, 0, "dwell_live2");
        cyc(1, 0, 0, 0, 0, db, 4'h1, 3'd0, 0, 0, "idle_d3b");

        // N_CH=6, W=4: out-of-range select and non-power-of-2 wrap
        cyc(2, 0, 1, 0, 7, dc, 4'h0, 3'd7, 0, 0, "oob_sel7");
        cyc(2, 0, 1, 0, 6, dc, 4'h0, 3'd6, 0, 0, "oob_sel6");
        cyc(2, 0, 1, 0, 5, dc, cval[5], 3'd5, 1, 0, "sel5");
        cyc(2, 0, 1, 0, 2, dc, cval[2], 3'd2, 1, 0, "sel2");
        for (int k = 0; k < 14; k++)
            cyc(2, 0, 1, 1, 0, dc, cval[k%6], 3'(k%6), 1, (k%6 == 5), "scan_n6");
        cyc(2, 0, 1, 0, 7, dc, 4'h0, 3'd7, 0, 0, "oob_after_scan");

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
